// File: rtl/turn_sequencer.sv
// Turn manager for 2..MAX_PLAYERS players. Skips eliminated players, counts rounds,
// optionally forces an advance on a per-turn timeout, and declares a winner or a draw.
module turn_sequencer #(
    parameter int MAX_PLAYERS = 4,
    parameter int PID_W       = 2,
    parameter int TIMEOUT_CYC = 0,
    parameter int ROUND_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PID_W:0]         num_players,
    input  logic                   advance,
    input  logic [MAX_PLAYERS-1:0] elim_mask,
    output logic [PID_W-1:0]       turn,
    output logic                   turn_valid,
    output logic                   turn_change,
    output logic [ROUND_W-1:0]     round_cnt,
    output logic                   timeout,
    output logic                   winner_valid,
    output logic                   draw,
    output logic                   cfg_err
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t             state_q, state_d;
    logic [PID_W-1:0]   turn_q, turn_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [PID_W:0]     n_q, n_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               adv_q;
    logic               chg_q, chg_d, tmo_q, tmo_d, win_q, win_d, draw_q, draw_d, cfg_q, cfg_d;

    logic [PID_W:0]     n_sel, act_cnt;
    logic [MAX_PLAYERS-1:0] act;
    logic [PID_W-1:0]   lowest, above, nxt;
    logic               has_above, wrap, adv_evt, elim_cur, tmo_hit, bad_cfg;

    // Before a game starts the player count comes straight from the input,
    // so start can decide PLAY vs DONE in the same cycle it latches N.
    always_comb begin
        n_sel     = (state_q == PLAY) ? n_q : num_players;
        act       = '0;
        act_cnt   = '0;
        lowest    = '0;
        above     = '0;
        has_above = 1'b0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            act[i] = (i < int'(n_sel)) && !elim_mask[i];
            if (act[i]) begin
                lowest = PID_W'(i);
                if (i > int'(turn_q)) begin
                    above     = PID_W'(i);
                    has_above = 1'b1;
                end
            end
        end
        for (int i = 0; i < MAX_PLAYERS; i++)
            act_cnt = act_cnt + {{PID_W{1'b0}}, act[i]};
        nxt  = has_above ? above : lowest;
        wrap = !has_above;
    end

    assign adv_evt  = advance && !adv_q;
    assign elim_cur = elim_mask[turn_q];
    assign tmo_hit  = (TIMEOUT_CYC > 0) && (tcnt_q == TMO_LAST);
    assign bad_cfg  = (num_players < 2) || (num_players > (PID_W+1)'(MAX_PLAYERS));

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        round_d = round_q;
        n_d     = n_q;
        tcnt_d  = '0;
        chg_d   = 1'b0;
        tmo_d   = 1'b0;
        win_d   = win_q;
        draw_d  = draw_q;
        cfg_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (bad_cfg) begin
                        cfg_d = 1'b1;
                    end else begin
                        n_d     = num_players;
                        round_d = '0;
                        win_d   = 1'b0;
                        draw_d  = 1'b0;
                        if (act_cnt >= 2) begin
                            state_d = PLAY;
                            turn_d  = lowest;
                            chg_d   = 1'b1;
                        end else begin
                            state_d = DONE;
                            if (act_cnt == 1) begin
                                turn_d = lowest;
                                win_d  = 1'b1;
                            end else begin
                                draw_d = 1'b1;
                            end
                        end
                    end
                end
            end
            PLAY: begin
                if (act_cnt <= 1) begin
                    state_d = DONE;
                    if (act_cnt == 1) begin
                        turn_d = lowest;
                        win_d  = 1'b1;
                    end else begin
                        draw_d = 1'b1;
                    end
                end else if (adv_evt || elim_cur || tmo_hit) begin
                    // Any mix of causes collapses into one advance.
                    turn_d = nxt;
                    chg_d  = 1'b1;
                    tmo_d  = tmo_hit && !adv_evt && !elim_cur;
                    if (wrap && (round_q != '1))
                        round_d = round_q + 1'b1;
                end else if (TIMEOUT_CYC > 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            turn_q  <= '0;
            round_q <= '0;
            n_q     <= '0;
            tcnt_q  <= '0;
            adv_q   <= 1'b0;
            chg_q   <= 1'b0;
            tmo_q   <= 1'b0;
            win_q   <= 1'b0;
            draw_q  <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            round_q <= round_d;
            n_q     <= n_d;
            tcnt_q  <= tcnt_d;
            adv_q   <= advance;
            chg_q   <= chg_d;
            tmo_q   <= tmo_d;
            win_q   <= win_d;
            draw_q  <= draw_d;
            cfg_q   <= cfg_d;
        end
    end

    assign turn         = turn_q;
    assign turn_valid   = (state_q == PLAY);
    assign turn_change  = chg_q;
    assign round_cnt    = round_q;
    assign timeout      = tmo_q;
    assign winner_valid = win_q;
    assign draw         = draw_q;
    assign cfg_err      = cfg_q;
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised turn manager for the multi-player board-game controller. It supersedes the fixed 2-player toggle.
- Tracks whose turn it is for 2..MAX_PLAYERS players and skips eliminated players.
- Counts rounds, forces a turn change on an optional per-turn timeout, and declares a winner when one active player remains.
- Sits between the game-state FSM, which drives advance and start, and the display/scoring logic.

Parameters:
- MAX_PLAYERS, 4, maximum number of players supported (≥2).
- PID_W, 2, player index width; must equal clog2(MAX_PLAYERS).
- TIMEOUT_CYC, 0, clock cycles allowed per turn before a forced advance; 0 disables the timeout.
- ROUND_W, 8, width of the round counter.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- start, input, 1, level; sampled each cycle. Begins a game from IDLE or DONE.
- num_players, input, PID_W+1, player count; sampled only when start is accepted.
- advance, input, 1, level from the game FSM. The block rising-edge detects it internally.
- elim_mask, input, MAX_PLAYERS, bit i=1 means player i is eliminated; live during play.
- turn, output, PID_W, index of the current player.
- turn_valid, output, 1, high while in PLAY.
- turn_change, output, 1, one-cycle pulse whenever turn is updated in PLAY.
- round_cnt, output, ROUND_W, completed rounds; saturating.
- timeout, output, 1, one-cycle pulse when a timeout forces an advance.
- winner_valid, output, 1, high in DONE when exactly one active player remains; turn then holds the winner.
- draw, output, 1, high in DONE when no active players remain.
- cfg_err, output, 1, one-cycle pulse when start is rejected.

Behaviour:
- Reset values (async): state=IDLE, turn=0, round_cnt=0, all flags 0, advance edge register=0, timeout counter=0.
- Definitions:
  - Active set: players i < N_reg with elim_mask[i]==0, where N_reg is num_players latched at start.
  - next(p): the first active index scanning p+1, p+2, … modulo N_reg, excluding p. Combinational priority search over MAX_PLAYERS candidates.
- States: IDLE, PLAY, DONE.
- IDLE/DONE, start=1:
  - num_players <2 or >MAX_PLAYERS: cfg_err pulses next cycle and the state is unchanged.
  - Otherwise latch N_reg, clear round_cnt, winner_valid and draw.
  - Active count ≥2: enter PLAY with turn = lowest active index; turn_change pulses.
  - Active count ≤1: enter DONE directly; winner_valid or draw is set accordingly.
- PLAY, advance event:
  - An advance event is advance=1 with the previous sample 0. Holding advance high gives exactly one advance.
  - On the next edge, turn ← next(turn), turn_change=1, and the timeout counter clears.
  - Latency from the advance rise to the turn update is 1 cycle.
- Forced advance on elimination: if elim_mask[turn]==1 in PLAY, the block advances on the next edge exactly like an advance event.
- Wrap: if next(turn) ≤ turn, round_cnt increments, saturating at all-ones.
- Timeout (TIMEOUT_CYC>0): the counter increments each PLAY cycle. When it reaches TIMEOUT_CYC-1 with no other advance cause, the block advances and pulses timeout.
- Simultaneous causes (advance edge, elimination, timeout in the same cycle): exactly one advance occurs. timeout pulses only if timeout was the sole cause.
- End of game:
  - Whenever the active count drops to ≤1 in PLAY, go to DONE next edge instead of advancing.
  - One active player: turn = that index, winner_valid=1.
  - Zero active players: draw=1 and turn is held.
  - turn_valid=0 and turn_change=0 in DONE.
- Inputs outside PLAY: num_players changes after start are ignored. advance in IDLE/DONE is ignored, but its edge register still tracks the input.
- rst mid-game: immediately returns to IDLE with all outputs at reset values.

Test Plan:
1. Reset, then start with num_players=2, elim_mask=0 → turn=0, turn_valid=1. Four advance pulses → turn 1,0,1,0; round_cnt=2.
2. N=4, elim_mask=4'b0100, starting at turn=1, advance → turn=3 (player 2 skipped). Next advance → turn=0, round_cnt+1.
3. N=3, turn=1, set elim_mask=3'b010 → auto-advance to turn=2 next cycle with a turn_change pulse. Then set elim_mask=3'b011 → DONE, winner_valid=1, turn=2.
4. TIMEOUT_CYC=5, N=2, no advance → timeout pulses and turn toggles every 5 cycles. An advance edge on the same cycle as expiry → single advance, timeout stays 0.
5. start with num_players=1, and start with num_players=5 (MAX=4) → cfg_err pulse each time, state stays IDLE. advance held high for 10 cycles in PLAY → exactly one turn change.
6. Assert rst mid-PLAY with turn=3, round_cnt=7 → turn=0, round_cnt=0, turn_valid=0 immediately. start with elim_mask all 1 → DONE with draw=1.
